// File: rtl/speicher_steuerung_if.sv
// Memory-side bus between the CPU and speicher_steuerung.
// The CPU is the master and raises the requests; the memory is the slave and acknowledges them.
interface speicher_steuerung_if;
    logic [31:0] InstruktionAdresse;
    logic        LeseInstruktion;
    logic [31:0] Instruktion;
    logic        InstruktionGeladen;
    logic [31:0] DatenAdresse;
    logic [31:0] DatenRaus;
    logic        LeseDaten;
    logic        SchreibeDaten;
    logic [31:0] DatenRein;
    logic        DatenGeladen;
    logic        DatenGespeichert;

    modport master (
        output InstruktionAdresse, LeseInstruktion, DatenAdresse, DatenRaus,
               LeseDaten, SchreibeDaten,
        input  Instruktion, InstruktionGeladen, DatenRein, DatenGeladen, DatenGespeichert
    );

    modport slave (
        input  InstruktionAdresse, LeseInstruktion, DatenAdresse, DatenRaus,
               LeseDaten, SchreibeDaten,
        output Instruktion, InstruktionGeladen, DatenRein, DatenGeladen, DatenGespeichert
    );
endinterface

// File: rtl/speicher_steuerung.sv
// Single-port word RAM shared by instruction fetch and data load/store.
// Requests are arbitrated with data priority and served after a fixed wait latency.
//
// state     | meaning
// BEREIT    | idle; arbitrate store > load > fetch and capture the winner
// WARTEN    | count down the configured wait cycles
// ANTWORT   | one-cycle access; the acknowledge is visible here
// ABSCHLUSS | hold until the served request line drops
module speicher_steuerung #(
    parameter int ADRESSBREITE = 10,
    parameter int WARTEZYKLEN  = 2,
    parameter     INITDATEI    = ""
) (
    input logic Clock,
    input logic Reset,
    speicher_steuerung_if.slave bus
);

    typedef enum logic [1:0] {BEREIT, WARTEN, ANTWORT, ABSCHLUSS} zustandT;
    typedef enum logic [1:0] {KEIN, HOLEN, LESEN, SCHREIBEN} portT;

    localparam int         TIEFE     = 2 ** ADRESSBREITE;
    localparam logic [3:0] WARTELAST = 4'(WARTEZYKLEN);

    logic [31:0] speicher [TIEFE];

    zustandT                 zustand, zustandNext;
    logic [3:0]              zaehler, zaehlerNext;
    portT                    portId, portIdNext;
    logic [ADRESSBREITE-1:0] adresse, adresseNext;
    logic                    ausserhalb, ausserhalbNext;
    logic [31:0]             schreibWert, schreibWertNext;

    logic [31:0] instruktionQ, instruktionNext;
    logic [31:0] datenReinQ, datenReinNext;
    logic        instrGeladenQ, instrGeladenNext;
    logic        datenGeladenQ, datenGeladenNext;
    logic        datenGespeichertQ, datenGespeichertNext;

    logic        zugriff;
    logic        aktiveLeitung;
    logic [31:0] leseWert;

    always_comb begin
        aktiveLeitung = 1'b0;
        case (portId)
            HOLEN:     aktiveLeitung = bus.LeseInstruktion;
            LESEN:     aktiveLeitung = bus.LeseDaten;
            SCHREIBEN: aktiveLeitung = bus.SchreibeDaten;
            default:   aktiveLeitung = 1'b0;
        endcase
    end

    always_comb begin
        zustandNext          = zustand;
        zaehlerNext          = zaehler;
        portIdNext           = portId;
        adresseNext          = adresse;
        ausserhalbNext       = ausserhalb;
        schreibWertNext      = schreibWert;
        instruktionNext      = instruktionQ;
        datenReinNext        = datenReinQ;
        instrGeladenNext     = 1'b0;
        datenGeladenNext     = 1'b0;
        datenGespeichertNext = 1'b0;
        zugriff              = 1'b0;
        leseWert             = '0;

        case (zustand)
            BEREIT: begin
                if (bus.SchreibeDaten) begin
                    portIdNext      = SCHREIBEN;
                    adresseNext     = bus.DatenAdresse[ADRESSBREITE-1:0];
                    ausserhalbNext  = |bus.DatenAdresse[31:ADRESSBREITE];
                    schreibWertNext = bus.DatenRaus;
                end else if (bus.LeseDaten) begin
                    portIdNext      = LESEN;
                    adresseNext     = bus.DatenAdresse[ADRESSBREITE-1:0];
                    ausserhalbNext  = |bus.DatenAdresse[31:ADRESSBREITE];
                end else if (bus.LeseInstruktion) begin
                    portIdNext      = HOLEN;
                    adresseNext     = bus.InstruktionAdresse[ADRESSBREITE-1:0];
                    ausserhalbNext  = |bus.InstruktionAdresse[31:ADRESSBREITE];
                end
                if (bus.SchreibeDaten || bus.LeseDaten || bus.LeseInstruktion) begin
                    zaehlerNext = WARTELAST;
                    if (WARTEZYKLEN == 0) begin
                        zustandNext = ANTWORT;
                        zugriff     = 1'b1;
                    end else begin
                        zustandNext = WARTEN;
                    end
                end
            end
            WARTEN: begin
                // Leave one edge early so the registered acknowledge lands in ANTWORT.
                zaehlerNext = zaehler - 4'd1;
                if (zaehler <= 4'd1) begin
                    zaehlerNext = '0;
                    zustandNext = ANTWORT;
                    zugriff     = 1'b1;
                end
            end
            ANTWORT: begin
                zustandNext = ABSCHLUSS;
            end
            ABSCHLUSS: begin
                if (!aktiveLeitung) begin
                    zustandNext = BEREIT;
                end
            end
            default: begin
                zustandNext = BEREIT;
            end
        endcase

        // Read data is registered on the edge into ANTWORT so it appears with its acknowledge.
        if (zugriff) begin
            leseWert = ausserhalbNext ? 32'h0000_0000 : speicher[adresseNext];
            case (portIdNext)
                HOLEN: begin
                    instrGeladenNext = 1'b1;
                    instruktionNext  = leseWert;
                end
                LESEN: begin
                    datenGeladenNext = 1'b1;
                    datenReinNext    = leseWert;
                end
                SCHREIBEN: begin
                    datenGespeichertNext = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            zustand           <= BEREIT;
            zaehler           <= '0;
            portId            <= KEIN;
            adresse           <= '0;
            ausserhalb        <= 1'b0;
            schreibWert       <= '0;
            instruktionQ      <= '0;
            datenReinQ        <= '0;
            instrGeladenQ     <= 1'b0;
            datenGeladenQ     <= 1'b0;
            datenGespeichertQ <= 1'b0;
        end else begin
            zustand           <= zustandNext;
            zaehler           <= zaehlerNext;
            portId            <= portIdNext;
            adresse           <= adresseNext;
            ausserhalb        <= ausserhalbNext;
            schreibWert       <= schreibWertNext;
            instruktionQ      <= instruktionNext;
            datenReinQ        <= datenReinNext;
            instrGeladenQ     <= instrGeladenNext;
            datenGeladenQ     <= datenGeladenNext;
            datenGespeichertQ <= datenGespeichertNext;
        end
    end

    // The RAM is never cleared; a reset during ANTWORT suppresses the pending write.
    always_ff @(posedge Clock) begin
        if (Reset && zustand == ANTWORT && portId == SCHREIBEN && !ausserhalb) begin
            speicher[adresse] <= schreibWert;
        end
    end

    assign bus.Instruktion        = instruktionQ;
    assign bus.DatenRein          = datenReinQ;
    assign bus.InstruktionGeladen = instrGeladenQ;
    assign bus.DatenGeladen       = datenGeladenQ;
    assign bus.DatenGespeichert   = datenGespeichertQ;

endmodule

// File: tb/tb_speicher_steuerung.sv
// Directed bench for speicher_steuerung: one instance with two wait cycles, one with none.
module tb_speicher_steuerung;

    localparam int W = 2;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    speicher_steuerung_if busA ();
    speicher_steuerung_if busN ();

    speicher_steuerung #(.ADRESSBREITE(10), .WARTEZYKLEN(W)) dut (
        .Clock(Clock), .Reset(Reset), .bus(busA.slave)
    );
    speicher_steuerung #(.ADRESSBREITE(10), .WARTEZYKLEN(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .bus(busN.slave)
    );

    typedef struct {
        int          art;
        logic [31:0] wert;
    } erwartT;

    erwartT sb[$];
    int tests  = 0;
    int failed = 0;

    task automatic pruefe(input string tag, input logic [31:0] ist, input logic [31:0] soll);
        tests++;
        assert (ist === soll) else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, ist, soll);
        end
    endtask

    task automatic leerlauf(input int n);
        repeat (n) @(negedge Clock);
    endtask

    function automatic logic [2:0] acksA();
        return {busA.InstruktionGeladen, busA.DatenGeladen, busA.DatenGespeichert};
    endfunction

    function automatic logic [2:0] acksN();
        return {busN.InstruktionGeladen, busN.DatenGeladen, busN.DatenGespeichert};
    endfunction

    // art: 0 fetch, 1 load, 2 store. Inputs are scrambled after capture.
    task automatic zugriffA(input int art, input logic [31:0] adr, input logic [31:0] wert,
                            input logic [31:0] erwartet);
        erwartT      e;
        int          n;
        logic [2:0]  a;
        sb.push_back('{art, erwartet});
        @(negedge Clock);
        busA.DatenAdresse       = adr;
        busA.InstruktionAdresse = adr;
        busA.DatenRaus          = wert;
        busA.SchreibeDaten      = (art == 2);
        busA.LeseDaten          = (art == 1);
        busA.LeseInstruktion    = (art == 0);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
            if (n == 1) begin
                busA.DatenAdresse       = ~adr;
                busA.InstruktionAdresse = ~adr;
                busA.DatenRaus          = ~wert;
            end
            a = acksA();
        end while (a == 3'b000 && n < 40);
        e = sb.pop_front();
        pruefe("latenz", n, W + 1);
        pruefe("quittung", a, 3'b100 >> e.art);
        if (e.art == 0)      pruefe("instruktion", busA.Instruktion, e.wert);
        else if (e.art == 1) pruefe("datenrein", busA.DatenRein, e.wert);
        busA.SchreibeDaten   = 1'b0;
        busA.LeseDaten       = 1'b0;
        busA.LeseInstruktion = 1'b0;
        @(negedge Clock);
        pruefe("einzelpuls", acksA(), 3'b000);
        leerlauf(2);
    endtask

    initial begin
        erwartT     e;
        int         n;
        int         pulse;
        logic [2:0] a;
        logic [2:0] gesehen;

        busA.InstruktionAdresse = '0; busA.LeseInstruktion = 1'b0;
        busA.DatenAdresse = '0; busA.DatenRaus = '0;
        busA.LeseDaten = 1'b0; busA.SchreibeDaten = 1'b0;
        busN.InstruktionAdresse = '0; busN.LeseInstruktion = 1'b0;
        busN.DatenAdresse = '0; busN.DatenRaus = '0;
        busN.LeseDaten = 1'b0; busN.SchreibeDaten = 1'b0;

        leerlauf(3);
        pruefe("reset_instruktion", busA.Instruktion, 32'h0);
        pruefe("reset_datenrein", busA.DatenRein, 32'h0);
        pruefe("reset_quittungen", acksA(), 3'b000);
        pruefe("reset0_quittungen", acksN(), 3'b000);
        pruefe("reset0_instruktion", busN.Instruktion, 32'h0);
        Reset = 1'b1;
        leerlauf(1);

        // store then load
        zugriffA(2, 32'd0, 32'h0BAD_F00D, 32'h0);
        zugriffA(2, 32'd5, 32'hDEAD_BEEF, 32'h0);
        zugriffA(1, 32'd5, 32'h0, 32'hDEAD_BEEF);
        zugriffA(2, 32'd1, 32'h0101_0101, 32'h0);
        zugriffA(2, 32'd3, 32'hAAAA_5555, 32'h0);

        // arbitration: load beats fetch, fetch follows once the load line drops
        sb.push_back('{1, 32'h0101_0101});
        sb.push_back('{0, 32'h0BAD_F00D});
        @(negedge Clock);
        busA.LeseInstruktion = 1'b1; busA.InstruktionAdresse = 32'd0;
        busA.LeseDaten = 1'b1;       busA.DatenAdresse = 32'd1;
        n = 0;
        do begin @(negedge Clock); n++; a = acksA(); end while (a == 3'b000 && n < 40);
        e = sb.pop_front();
        pruefe("arb_latenz_laden", n, W + 1);
        pruefe("arb_erst_laden", a, 3'b010);
        pruefe("arb_datenrein", busA.DatenRein, e.wert);
        busA.LeseDaten = 1'b0;
        n = 0;
        do begin @(negedge Clock); n++; a = acksA(); end while (a == 3'b000 && n < 40);
        e = sb.pop_front();
        pruefe("arb_latenz_holen", n, W + 3);
        pruefe("arb_dann_holen", a, 3'b100);
        pruefe("arb_instruktion", busA.Instruktion, e.wert);
        busA.LeseInstruktion = 1'b0;
        leerlauf(3);

        // held fetch request is served once
        sb.push_back('{0, 32'hDEAD_BEEF});
        busA.LeseInstruktion = 1'b1; busA.InstruktionAdresse = 32'd5;
        pulse = 0;
        repeat (20) begin
            @(negedge Clock);
            if (busA.InstruktionGeladen) pulse++;
        end
        e = sb.pop_front();
        pruefe("gehalten_pulse", pulse, 1);
        pruefe("gehalten_instruktion", busA.Instruktion, e.wert);
        busA.LeseInstruktion = 1'b0;
        leerlauf(3);
        pruefe("gehalten_stabil", busA.Instruktion, 32'hDEAD_BEEF);

        // out of range
        zugriffA(2, 32'h400, 32'h1234_5678, 32'h0);
        zugriffA(1, 32'd0, 32'h0, 32'h0BAD_F00D);
        zugriffA(1, 32'h400, 32'h0, 32'h0);
        zugriffA(0, 32'h8000_0005, 32'h0, 32'h0);
        zugriffA(1, 32'd3, 32'h0, 32'hAAAA_5555);

        // reset during WARTEN of a store
        @(negedge Clock);
        busA.SchreibeDaten = 1'b1; busA.DatenAdresse = 32'd3; busA.DatenRaus = 32'h5A5A_5A5A;
        @(negedge Clock);
        Reset = 1'b0;
        busA.SchreibeDaten = 1'b0;
        gesehen = 3'b000;
        repeat (3) begin
            @(negedge Clock);
            gesehen = gesehen | acksA();
        end
        pruefe("reset_keine_quittung", gesehen, 3'b000);
        pruefe("reset_mitte_datenrein", busA.DatenRein, 32'h0);
        pruefe("reset_mitte_instruktion", busA.Instruktion, 32'h0);
        Reset = 1'b1;
        leerlauf(1);
        zugriffA(1, 32'd3, 32'h0, 32'hAAAA_5555);

        // zero wait cycles
        sb.push_back('{2, 32'h0});
        @(negedge Clock);
        busN.SchreibeDaten = 1'b1; busN.DatenAdresse = 32'd2; busN.DatenRaus = 32'hCAFE_F00D;
        @(negedge Clock);
        e = sb.pop_front();
        pruefe("w0_speichern", acksN(), 3'b001);
        busN.SchreibeDaten = 1'b0;
        @(negedge Clock);
        pruefe("w0_einzelpuls", acksN(), 3'b000);
        leerlauf(2);
        sb.push_back('{0, 32'hCAFE_F00D});
        busN.LeseInstruktion = 1'b1; busN.InstruktionAdresse = 32'd2;
        @(negedge Clock);
        e = sb.pop_front();
        pruefe("w0_holen", acksN(), 3'b100);
        pruefe("w0_instruktion", busN.Instruktion, e.wert);
        busN.LeseInstruktion = 1'b0;
        @(negedge Clock);
        pruefe("w0_holen_puls", acksN(), 3'b000);
        leerlauf(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
